// File: rtl/digit_scan_display.sv
// Four-digit multiplexed common-anode seven-segment scanner.
// Inputs are snapshotted once per frame; all pins are registered.
module digit_scan_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [DIV_WIDTH-1:0] P_LAST  = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] P_BLANK = DIV_WIDTH'(BLANK_CYCLES);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] p_q, p_d;
  logic [1:0]           s_q, s_d;
  logic [15:0]          dig_q, dig_d;
  logic [3:0]           dpm_q, dpm_d;
  logic                 lz_q, lz_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 ft_q, ft_d;

  logic [3:0] cur;
  logic       z3, z32, z321, hide;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] r;
    unique case (v)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    dig_d   = dig_q;
    dpm_d   = dpm_q;
    lz_d    = lz_q;
    an_d    = 4'b1111;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    ft_d    = 1'b0;
    cur     = 4'd0;
    hide    = 1'b0;
    z3      = 1'b0;
    z32     = 1'b0;
    z321    = 1'b0;
    unique case (state_q)
      IDLE: begin
        p_d = '0;
        s_d = 2'd0;
        if (en) state_d = SCAN;
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          p_d     = '0;
          s_d     = 2'd0;
        end else begin
          if (p_q == '0 && s_q == 2'd0) begin
            dig_d = digits;
            dpm_d = dp_mask;
            lz_d  = lz_blank;
            ft_d  = 1'b1;
          end
          if (p_q == P_LAST) begin
            p_d = '0;
            s_d = s_q + 2'd1;
          end else begin
            p_d = p_q + DIV_WIDTH'(1);
          end
          // Decode from the snapshot being loaded so a zero dead time
          // still shows the new frame's first digit.
          z3   = dig_d[15:12] == 4'd0;
          z32  = z3 && dig_d[11:8] == 4'd0;
          z321 = z32 && dig_d[7:4] == 4'd0;
          unique case (s_q)
            2'd3:    hide = z3;
            2'd2:    hide = z32;
            2'd1:    hide = z321;
            default: hide = 1'b0;
          endcase
          if (p_q >= P_BLANK) begin
            cur   = dig_d[{s_q, 2'b00} +: 4];
            an_d  = ~(4'b0001 << s_q);
            seg_d = (lz_d && hide) ? 7'b1111111 : dec(cur);
            dp_d  = ~dpm_d[s_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= 2'd0;
      dig_q   <= 16'd0;
      dpm_q   <= 4'd0;
      lz_q    <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      dig_q   <= dig_d;
      dpm_q   <= dpm_d;
      lz_q    <= lz_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ft_q    <= ft_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_digit_scan_display.sv
// Bench for digit_scan_display with a frame-position reference model.
// Random and directed scenarios, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_digit_scan_display;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  digit_scan_display #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK),
    .DIV_WIDTH   (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .lz_blank  (lz_blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  // Model: running flag plus position t within the frame.
  bit         m_run = 0;
  int         m_t = 0;
  logic [3:0] m_snap [4];
  logic [3:0] m_dpm = 4'h0;
  logic       m_lz = 1'b0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;
  logic       m_ft = 1'b0;

  task automatic step();
    int  slot;
    int  pos;
    bit  zero;
    m_an  = 4'hF;
    m_seg = 7'h7F;
    m_dp  = 1'b1;
    m_ft  = 1'b0;
    if (clr) begin
      m_run = 0;
      m_t   = 0;
      for (int j = 0; j < 4; j++) m_snap[j] = 4'h0;
      m_dpm = 4'h0;
      m_lz  = 1'b0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1;
        m_t   = 0;
      end
    end else if (!en) begin
      m_run = 0;
      m_t   = 0;
    end else begin
      if (m_t == 0) begin
        for (int j = 0; j < 4; j++) m_snap[j] = digits[4*j +: 4];
        m_dpm = dp_mask;
        m_lz  = lz_blank;
        m_ft  = 1'b1;
      end
      slot = m_t / DIV;
      pos  = m_t % DIV;
      if (pos >= BLANK) begin
        m_an[slot] = 1'b0;
        zero = m_lz && (slot > 0);
        for (int j = slot; j < 4; j++)
          if (m_snap[j] != 4'h0) zero = 0;
        m_seg = zero ? 7'h7F : seg_tab[m_snap[slot]];
        m_dp  = ~m_dpm[slot];
      end
      m_t = (m_t + 1) % FRAME;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    bit got = 0;
    for (int i = 0; i < FRAME + 4 && !got; i++) begin
      step();
      got = frame_tick;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_tick_timeout got=no_tick want=tick", name);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    en  = 1'b1;
    step();
    step();
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset got=%b_%b_%b_%b want=1111_1111111_1_0",
               an, seg, dp, frame_tick);
    end
    en = 1'b0;
    step();
    clr = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int ticks = 0;
    int first = -1;
    int second = -1;
    logic [6:0] want;
    digits   = 16'h1234;
    dp_mask  = 4'h0;
    lz_blank = 1'b0;
    en       = 1'b1;
    step();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL basic_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
      if (frame_tick) begin
        ticks++;
        if (first < 0) first = i;
        else second = i;
      end
      want = 7'h7F;
      unique case (an)
        4'b1110: want = 7'b0011001;
        4'b1101: want = 7'b0110000;
        4'b1011: want = 7'b0100100;
        4'b0111: want = 7'b1111001;
        default: want = 7'h7F;
      endcase
      checks++;
      if (seg !== want) begin
        failures++;
        $display("FAIL basic_seg i=%0d an=%b got=%b want=%b",
                 i, an, seg, want);
      end
    end
    checks++;
    if (ticks != 2 || second - first != FRAME) begin
      failures++;
      $display("FAIL basic_tick_period got=%0d_ticks_gap%0d want=2_ticks_gap%0d",
               ticks, second - first, FRAME);
    end
  endtask

  task automatic test_lz();
    logic [6:0] want;
    bit seen = 0;
    digits   = 16'h0050;
    lz_blank = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      seen = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        step();
        checks++;
        if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
          failures++;
          $display("FAIL lz_model ph=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                   ph, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
        end
        if (frame_tick) seen = 1;
        if (seen && an != 4'hF) begin
          unique case (an)
            4'b0111: want = (ph == 0) ? 7'h7F : 7'b1000000;
            4'b1011: want = (ph == 0) ? 7'h7F : 7'b1000000;
            4'b1101: want = 7'b0010010;
            default: want = 7'b1000000;
          endcase
          checks++;
          if (seg !== want) begin
            failures++;
            $display("FAIL lz_seg ph=%0d an=%b got=%b want=%b",
                     ph, an, seg, want);
          end
        end
      end
      lz_blank = 1'b0;
    end
  endtask

  task automatic test_midframe();
    bit after = 0;
    digits = 16'h1111;
    wait_tick("mid_a");
    wait_tick("mid_b");
    for (int i = 0; i < DIV + 3; i++) step();
    digits = 16'h2222;
    for (int i = 0; i < 2 * FRAME - DIV - 4; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL mid_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
      if (frame_tick) after = 1;
      if (an != 4'hF) begin
        checks++;
        if (seg !== (after ? 7'b0100100 : 7'b1111001)) begin
          failures++;
          $display("FAIL mid_seg i=%0d after=%0d got=%b", i, after, seg);
        end
      end
    end
  endtask

  task automatic test_invalid_dp();
    digits  = 16'h5C37;
    dp_mask = 4'b0100;
    wait_tick("inv_a");
    wait_tick("inv_b");
    for (int i = 0; i < FRAME - 1; i++) begin
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL inv_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
      checks++;
      if (an == 4'b1011) begin
        if (seg !== 7'b0111111 || dp !== 1'b0) begin
          failures++;
          $display("FAIL inv_slot2 got=%b_%b want=0111111_0", seg, dp);
        end
      end else if (dp !== 1'b1) begin
        failures++;
        $display("FAIL inv_dp an=%b got=%b want=1", an, dp);
      end
      step();
    end
    dp_mask = 4'h0;
  endtask

  task automatic test_enable_drop();
    digits = 16'h4444;
    wait_tick("en_a");
    for (int i = 0; i < 2 * DIV + 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL en_off i=%0d got=%b_%b_%b_%b want=1111_1111111_1_0",
                 i, an, seg, dp, frame_tick);
      end
    end
    digits = 16'h9876;
    en     = 1'b1;
    step();
    step();
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL en_restart_tick got=%b want=1", frame_tick);
    end
    for (int i = 0; i < DIV; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL en_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
      if (an == 4'b1110) begin
        checks++;
        if (seg !== 7'b0000010) begin
          failures++;
          $display("FAIL en_slot0 got=%b want=0000010", seg);
        end
      end
    end
  endtask

  task automatic test_clr_mid();
    digits = 16'h8888;
    wait_tick("clr_a");
    for (int i = 0; i < 4; i++) step();
    clr = 1'b1;
    step();
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL clr_mid got=%b_%b_%b_%b want=1111_1111111_1_0",
               an, seg, dp, frame_tick);
    end
    clr    = 1'b0;
    digits = 16'h4321;
    step();
    step();
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL clr_restart_tick got=%b want=1", frame_tick);
    end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL clr_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
      if (an == 4'b1110) begin
        checks++;
        if (seg !== 7'b1111001) begin
          failures++;
          $display("FAIL clr_slot0 got=%b want=1111001", seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      digits   = 16'($urandom);
      dp_mask  = 4'($urandom);
      lz_blank = 1'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int j = 0; j < 4; j++)
          if (digits[4*j +: 4] > 4'd9) digits[4*j +: 4] = 4'd0;
      if ($urandom_range(0, 149) == 0) en = ~en;
      clr = ($urandom_range(0, 399) == 0);
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== {m_an, m_seg, m_dp, m_ft}) begin
        failures++;
        $display("FAIL rand_model i=%0d got=%b_%b_%b_%b want=%b_%b_%b_%b",
                 i, an, seg, dp, frame_tick, m_an, m_seg, m_dp, m_ft);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) m_snap[j] = 4'h0;
    test_reset();
    test_basic();
    test_lz();
    test_midframe();
    test_invalid_dp();
    test_enable_drop();
    test_clr_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
